// File: rtl/uart_mem_loader.sv
// uart_mem_loader
// ---------------
// Front-end for the systolic array. Receives 8N1 bytes on a UART RX line,
// writes them to consecutive operand-memory addresses and, once a full image
// of NUM_BYTES has been written, holds start high until the array reports
// finish. It then goes back to loading the next image from address 0.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   rx         UART serial input (idle high, asynchronous to clk)
//   finish     completion indication from the array
//   wr_en      one-cycle memory write strobe
//   wr_addr    memory write address
//   wr_data    memory write data
//   start      run request to the array (held level)
//   busy       high while a frame is being received
//   frame_err  one-cycle pulse on a bad stop bit
//   overrun    one-cycle pulse when a byte arrives while start is high
module uart_mem_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 14,
    parameter int DATA_W       = 8,
    parameter int NUM_BYTES    = 16384
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    input  logic              finish,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              start,
    output logic              busy,
    output logic              frame_err,
    output logic              overrun
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0]  HALF_M1   = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  FULL_M1   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);
    // Terminal address compared by value, so NUM_BYTES == 2**ADDR_W works
    // with the counter simply rolling over.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BYTES - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_IDLE
    } rx_state_t;

    typedef enum logic {
        LD_LOAD,
        LD_RUN
    } ld_state_t;

    // Synchronizer resets to the idle line level so reset never looks like
    // a start bit.
    logic sync1_q, sync2_q;
    logic rx_s;

    rx_state_t          rx_state_q, rx_state_d;
    logic [CNT_W-1:0]   baud_q, baud_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic               byte_ok;
    logic               stop_bad;

    ld_state_t          ld_state_q, ld_state_d;
    logic               armed_q, armed_d;
    logic               wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;
    logic               start_q, start_d;
    logic               busy_q, busy_d;
    logic               frame_err_q, frame_err_d;
    logic               overrun_q, overrun_d;

    assign rx_s = sync2_q;

    // Receiver: start bit is re-checked at its midpoint, then every data
    // bit and the stop bit are sampled one full bit period apart.
    always_comb begin
        rx_state_d = rx_state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        byte_ok    = 1'b0;
        stop_bad   = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_s) begin
                    rx_state_d = RX_START;
                    baud_d     = '0;
                end
            end
            RX_START: begin
                if (baud_q == HALF_M1) begin
                    baud_d = '0;
                    if (rx_s) begin
                        rx_state_d = RX_IDLE;   // glitch, not a real start bit
                    end else begin
                        rx_state_d = RX_DATA;
                        bit_d      = '0;
                    end
                end else begin
                    baud_d = baud_q + CNT_ONE;
                end
            end
            RX_DATA: begin
                if (baud_q == FULL_M1) begin
                    baud_d  = '0;
                    shift_d = {rx_s, shift_q[DATA_W-1:1]};  // LSB first
                    if (bit_q == LAST_BIT) begin
                        rx_state_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + BIT_ONE;
                    end
                end else begin
                    baud_d = baud_q + CNT_ONE;
                end
            end
            RX_STOP: begin
                if (baud_q == FULL_M1) begin
                    baud_d = '0;
                    if (rx_s) begin
                        byte_ok    = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        stop_bad   = 1'b1;
                        rx_state_d = RX_WAIT_IDLE;
                    end
                end else begin
                    baud_d = baud_q + CNT_ONE;
                end
            end
            RX_WAIT_IDLE: begin
                // A held-low line (break) must return high before we re-arm.
                if (rx_s) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Loader: turns received bytes into writes, sequences start/finish.
    always_comb begin
        ld_state_d  = ld_state_q;
        armed_d     = armed_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        start_d     = start_q;
        busy_d      = (rx_state_d != RX_IDLE);
        frame_err_d = stop_bad;
        overrun_d   = 1'b0;

        if (byte_ok) begin
            if (ld_state_q == LD_LOAD) begin
                wr_en_d   = 1'b1;
                wr_data_d = shift_q;
            end else begin
                overrun_d = 1'b1;
            end
        end

        case (ld_state_q)
            LD_LOAD: begin
                // Address advances only after the write strobe has been seen.
                if (wr_en_q) begin
                    if (wr_addr_q == LAST_ADDR) begin
                        wr_addr_d  = '0;
                        start_d    = 1'b1;
                        armed_d    = 1'b0;
                        ld_state_d = LD_RUN;
                    end else begin
                        wr_addr_d = wr_addr_q + ADDR_ONE;
                    end
                end
            end
            LD_RUN: begin
                // finish is ignored in the first cycle start is high.
                if (!armed_q) begin
                    armed_d = 1'b1;
                end else if (finish) begin
                    start_d    = 1'b0;
                    armed_d    = 1'b0;
                    ld_state_d = LD_LOAD;
                end
            end
            default: ld_state_d = LD_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            rx_state_q  <= RX_IDLE;
            baud_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            ld_state_q  <= LD_LOAD;
            armed_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= rx;
            sync2_q     <= sync1_q;
            rx_state_q  <= rx_state_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            ld_state_q  <= ld_state_d;
            armed_q     <= armed_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            start_q     <= start_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign start     = start_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Testbench for uart_mem_loader (CLKS_PER_BIT=4, NUM_BYTES=4).
// Stimulus pushes expected events into a queue from a simple image-loading
// model; a separate monitor pops and compares whenever the DUT emits a
// write, overrun, frame error or start rise.
module tb_uart_mem_loader;

    localparam int CPB = 4;
    localparam int NB  = 4;
    localparam int AW  = 14;
    localparam int DW  = 8;

    localparam int K_WR    = 0;
    localparam int K_OVR   = 1;
    localparam int K_FERR  = 2;
    localparam int K_START = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx = 1'b1;
    logic          finish = 1'b0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          start;
    logic          busy;
    logic          frame_err;
    logic          overrun;

    always #5 clk = ~clk;

    uart_mem_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .NUM_BYTES   (NB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .finish   (finish),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .start    (start),
        .busy     (busy),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    typedef struct {
        int kind;
        int addr;
        int data;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_bad   = 0;

    // Reference model state: next address to fill, and whether the array
    // currently owns the image.
    int   m_addr    = 0;
    bit   m_running = 1'b0;

    function automatic void check(string name, int act, int req);
        n_total++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endfunction

    function automatic void push(int kind, int addr, int data);
        exp_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endfunction

    // Model of what one complete frame should cause.
    function automatic void model_frame(int d, bit good_stop);
        if (!good_stop) begin
            push(K_FERR, 0, 0);
        end else if (m_running) begin
            push(K_OVR, 0, 0);
        end else begin
            push(K_WR, m_addr, d);
            m_addr++;
            if (m_addr == NB) begin
                m_addr    = 0;
                m_running = 1'b1;
                push(K_START, 0, 0);
            end
        end
    endfunction

    function automatic void model_reset();
        m_addr    = 0;
        m_running = 1'b0;
    endfunction

    task automatic send_frame(input logic [7:0] d, input bit good_stop);
        model_frame(int'(d), good_stop);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CPB) @(negedge clk);
        end
        rx = good_stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic wait_start();
        int k = 0;
        while (!start && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("start_wait", int'(start), 1);
    endtask

    task automatic do_finish();
        wait_start();
        @(negedge clk);
        finish = 1'b1;
        @(negedge clk);
        finish = 1'b0;
        check("start_drop_after_finish", int'(start), 0);
        m_running = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("queue_drained", exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_wr_en",     int'(wr_en),     0);
        check("rst_wr_addr",   int'(wr_addr),   0);
        check("rst_wr_data",   int'(wr_data),   0);
        check("rst_start",     int'(start),     0);
        check("rst_busy",      int'(busy),      0);
        check("rst_frame_err", int'(frame_err), 0);
        check("rst_overrun",   int'(overrun),   0);
    endtask

    // Monitor: pops one expectation per observed DUT event.
    task automatic observe(int kind, int addr, int data, int cyc, int last_wr);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_total++;
            n_bad++;
            $display("FAIL unexpected_event: got kind %0d addr %0d data %0h want none", kind, addr, data);
            return;
        end
        e = exp_q.pop_front();
        $display("txn kind=%0d addr=%0d data=%02h cycle=%0d", kind, addr, data, cyc);
        check("event_kind", kind, e.kind);
        if (e.kind == K_WR && kind == K_WR) begin
            check("wr_addr", addr, e.addr);
            check("wr_data", data, e.data);
        end
        if (e.kind == K_START && kind == K_START) begin
            check("start_addr_zero", addr, 0);
            check("start_after_last_wr", cyc - last_wr, 1);
        end
    endtask

    initial begin
        int  cyc     = 0;
        int  last_wr = -100;
        bit  start_prev = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                if (wr_en) begin
                    observe(K_WR, int'(wr_addr), int'(wr_data), cyc, last_wr);
                    last_wr = cyc;
                end
                if (overrun)   observe(K_OVR, 0, 0, cyc, last_wr);
                if (frame_err) observe(K_FERR, 0, 0, cyc, last_wr);
                if (start && !start_prev) observe(K_START, int'(wr_addr), 0, cyc, last_wr);
            end
            start_prev = start;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat;
        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Load an image, expect start with address back at 0
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        send_frame(8'h33, 1'b1);
        send_frame(8'h44, 1'b1);
        wait_start();
        check("addr_after_image", int'(wr_addr), 0);

        // Byte during RUN -> overrun, then finish, then a new load at 0
        send_frame(8'h55, 1'b1);
        do_finish();
        send_frame(8'hA5, 1'b1);

        // Bad stop bit: error pulse, no write, address held
        send_frame(8'h3C, 1'b0);
        check("addr_after_frame_err", int'(wr_addr), m_addr);
        send_frame(8'h3C, 1'b1);

        // One-clock glitch on rx
        @(negedge clk);
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (8) @(negedge clk);
        check("busy_after_glitch", int'(busy), 0);
        check("addr_after_glitch", int'(wr_addr), m_addr);

        // Reset in the middle of data bit 4
        drain();
        pat = 8'h96;
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = pat[i];
            repeat (CPB) @(negedge clk);
        end
        rx = pat[4];
        repeat (2) @(negedge clk);
        check("busy_mid_frame", int'(busy), 1);
        #2 rst = 1'b1;
        #1 check_reset_outputs();
        rx = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);

        // Fresh image from 0, then reset while the array runs
        for (int i = 0; i < NB; i++) send_frame(8'($urandom_range(0, 255)), 1'b1);
        wait_start();
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 check("start_async_drop", int'(start), 0);
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);

        for (int i = 0; i < NB; i++) send_frame(8'($urandom_range(0, 255)), 1'b1);
        do_finish();

        // finish during LOAD after two bytes is ignored
        send_frame(8'($urandom_range(0, 255)), 1'b1);
        send_frame(8'($urandom_range(0, 255)), 1'b1);
        @(negedge clk);
        finish = 1'b1;
        @(negedge clk);
        finish = 1'b0;
        check("start_low_in_load", int'(start), 0);
        check("addr_unchanged_by_finish", int'(wr_addr), m_addr);
        send_frame(8'($urandom_range(0, 255)), 1'b1);
        send_frame(8'($urandom_range(0, 255)), 1'b1);
        do_finish();

        // Randomized traffic with occasional bad stop bits and random finishes
        for (int n = 0; n < 24; n++) begin
            send_frame(8'($urandom_range(0, 255)), $urandom_range(0, 5) != 0);
            if (m_running && $urandom_range(0, 1) == 1) do_finish();
        end

        drain();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
